// File: rtl/sr_latch_driver.sv
// Turns single-cycle set/clear requests into fixed-width, never-overlapping S/R pulses
// and confirms the latch followed via synchronized Q/Qbar feedback (done / sticky err).
module sr_latch_driver #(
    parameter int PULSE_CYCLES   = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 8,
    parameter int CW             = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_req,
    input  logic       clr_req,
    output logic       req_ready,
    input  logic       Q_fb,
    input  logic       Qbar_fb,
    output logic       S,
    output logic       R,
    output logic       busy,
    output logic       done,
    output logic [1:0] err,
    input  logic       err_clr
);

    localparam logic [63:0] CNT_MAX = (64'd1 << CW) - 64'd1;

    generate
        if (CW < 1 || CW > 32 ||
            PULSE_CYCLES < 1 || 64'(PULSE_CYCLES) > CNT_MAX ||
            GAP_CYCLES < 1 || 64'(GAP_CYCLES) > CNT_MAX ||
            TIMEOUT_CYCLES < 1 || 64'(TIMEOUT_CYCLES) > CNT_MAX) begin : g_bad_param
            $error("sr_latch_driver: cycle parameters must lie in 1..2^CW-1");
        end
    endgenerate

    localparam logic [CW-1:0] PULSE_LD   = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD     = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LD = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_CONFLICT = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_VERIFY,
        ST_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tgt_q, tgt_d;
    logic            s_q, s_d;
    logic            r_q, r_d;
    logic            done_q, done_d;
    logic [1:0]      err_q, err_d;
    logic [1:0]      new_err;
    logic            q_s1_q, q_s2_q, qb_s1_q, qb_s2_q;
    logic            fb_is_set, fb_is_clr;

    // Only a complementary pair counts as a confirmed state; qs==qbs is never a match.
    assign fb_is_set = q_s2_q & ~qb_s2_q;
    assign fb_is_clr = ~q_s2_q & qb_s2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        s_d     = 1'b0;
        r_d     = 1'b0;
        done_d  = 1'b0;
        new_err = ERR_NONE;
        case (state_q)
            ST_IDLE: begin
                if (set_req ^ clr_req) begin
                    tgt_d = set_req;
                    if (set_req ? fb_is_set : fb_is_clr) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LD;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_PULSE;
                        cnt_d   = PULSE_LD;
                        s_d     = set_req;
                        r_d     = clr_req;
                    end
                end else if (set_req & clr_req) begin
                    new_err = ERR_CONFLICT;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_VERIFY;
                    cnt_d   = TIMEOUT_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    s_d   = tgt_q;
                    r_d   = ~tgt_q;
                end
            end
            ST_VERIFY: begin
                if (tgt_q ? fb_is_set : fb_is_clr) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LD;
                    done_d  = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LD;
                    new_err = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (new_err != ERR_NONE) begin
            err_d = new_err;
        end else if (err_clr) begin
            err_d = ERR_NONE;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tgt_q   <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= ERR_NONE;
            q_s1_q  <= 1'b0;
            q_s2_q  <= 1'b0;
            qb_s1_q <= 1'b0;
            qb_s2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            done_q  <= done_d;
            err_q   <= err_d;
            q_s1_q  <= Q_fb;
            q_s2_q  <= q_s1_q;
            qb_s1_q <= Qbar_fb;
            qb_s2_q <= qb_s1_q;
        end
    end

    assign S         = s_q;
    assign R         = r_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q != ST_IDLE);
    assign req_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: behavioural NOR latch on the feedback, timeline-based reference
// model compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_sr_latch_driver;

    localparam int P  = 4;
    localparam int G  = 2;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       set_req = 1'b0;
    logic       clr_req = 1'b0;
    logic       err_clr = 1'b0;
    logic       Q_fb, Qbar_fb;
    logic       req_ready, S, R, busy, done;
    logic [1:0] err;

    logic lq = 1'b0;
    logic lqb = 1'b1;
    int   ovr = 0;   // 0: real latch, 1: stuck cleared, 2: both high

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sr_latch_driver dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_req  (set_req),
        .clr_req  (clr_req),
        .req_ready(req_ready),
        .Q_fb     (Q_fb),
        .Qbar_fb  (Qbar_fb),
        .S        (S),
        .R        (R),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_clr  (err_clr)
    );

    // Behavioural NOR SR latch.
    always @(S or R) begin
        if (S === 1'b1 && R !== 1'b1) begin
            lq = 1'b1; lqb = 1'b0;
        end else if (R === 1'b1 && S !== 1'b1) begin
            lq = 1'b0; lqb = 1'b1;
        end else if (S === 1'b1 && R === 1'b1) begin
            lq = 1'b0; lqb = 1'b0;
        end
    end

    assign Q_fb    = (ovr == 1) ? 1'b0 : (ovr == 2) ? 1'b1 : lq;
    assign Qbar_fb = (ovr == 1) ? 1'b1 : (ovr == 2) ? 1'b1 : lqb;

    // Reference model: each operation is a timeline of absolute cycle numbers.
    bit       exp_S = 0, exp_R = 0, exp_done = 0, exp_busy = 0, exp_rdy = 1;
    bit [1:0] exp_err = 0;

    initial begin
        int k, ka, vstart, vend, gfirst;
        bit op, tgt, qs, qbs, hit_set, hit_clr, in_pulse;
        bit [1:0] new_err;
        bit hq[$];
        bit hqb[$];
        k = 0; op = 0; tgt = 0; ka = 0; vstart = 0; vend = 0; gfirst = -1;
        hq = '{1'b0, 1'b0};
        hqb = '{1'b0, 1'b0};
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                k = 0; op = 0; gfirst = -1;
                hq = '{1'b0, 1'b0};
                hqb = '{1'b0, 1'b0};
                exp_S = 0; exp_R = 0; exp_done = 0; exp_err = 0; exp_busy = 0; exp_rdy = 1;
            end else begin
                k++;
                qs = hq.pop_front();
                qbs = hqb.pop_front();
                hq.push_back(Q_fb);
                hqb.push_back(Qbar_fb);
                hit_set = qs && !qbs;
                hit_clr = !qs && qbs;
                new_err = 2'b00;
                exp_done = 0;
                if (op && gfirst >= 0 && k - 1 >= gfirst + G) op = 0;
                if (!op) begin
                    if (set_req != clr_req) begin
                        op = 1; tgt = set_req; ka = k;
                        if (tgt ? hit_set : hit_clr) begin
                            gfirst = k; exp_done = 1;
                        end else begin
                            gfirst = -1; vstart = k + P; vend = k + P + TO - 1;
                        end
                    end else if (set_req && clr_req) begin
                        new_err = 2'b01;
                    end
                end else if (gfirst < 0 && k - 1 >= vstart) begin
                    if (tgt ? hit_set : hit_clr) begin
                        gfirst = k; exp_done = 1;
                    end else if (k - 1 == vend) begin
                        gfirst = k; new_err = 2'b10;
                    end
                end
                if (new_err != 2'b00) exp_err = new_err;
                else if (err_clr) exp_err = 2'b00;
                in_pulse = op && gfirst < 0 && k >= ka && k < vstart;
                exp_S = in_pulse && tgt;
                exp_R = in_pulse && !tgt;
                exp_busy = op && !(gfirst >= 0 && k >= gfirst + G);
                exp_rdy = !exp_busy;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checks++;
                if ({S, R, done, err, busy, req_ready} !==
                    {exp_S, exp_R, exp_done, exp_err, exp_busy, exp_rdy}) begin
                    errors++;
                    $display("FAIL cycle_model t=%0t got S%b R%b done%b err%b busy%b rdy%b exp S%b R%b done%b err%b busy%b rdy%b",
                             $time, S, R, done, err, busy, req_ready,
                             exp_S, exp_R, exp_done, exp_err, exp_busy, exp_rdy);
                end
            end
        end
    end

    initial begin
        forever begin
            @(S or R);
            assert (!(S === 1'b1 && R === 1'b1)) else begin
                errors++;
                $display("FAIL sr_overlap t=%0t got S=%b R=%b exp never both 1", $time, S, R);
            end
        end
    end

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, expv);
        end
    endtask

    // Issues one request cycle and records what the outputs did over the next n cycles.
    // Index i=1 is the cycle right after the accepting edge.
    task automatic run_op(input bit s, input bit c, input int n,
                          output int s_cnt, output int r_cnt, output int s_first,
                          output int s_fall, output int d_cnt, output int d_first,
                          output int e_first, output int e_val,
                          output int busy_cnt, output int busy_last);
        logic [1:0] e0;
        s_cnt = 0; r_cnt = 0; s_first = 0; s_fall = 0; d_cnt = 0; d_first = 0;
        e_first = 0; e_val = 0; busy_cnt = 0; busy_last = 0;
        @(posedge clk); #1;
        set_req = s; clr_req = c;
        e0 = err;
        @(posedge clk); #1;
        set_req = 1'b0; clr_req = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (S) begin
                s_cnt++;
                if (s_first == 0) s_first = i;
            end
            if (s_first != 0 && !S && s_fall == 0) s_fall = i;
            if (R) r_cnt++;
            if (done) begin
                d_cnt++;
                if (d_first == 0) d_first = i;
            end
            if (err != e0 && e_first == 0) begin
                e_first = i; e_val = int'(err);
            end
            if (busy) begin
                busy_cnt++; busy_last = i;
            end
        end
    endtask

    initial begin
        int sc, rc, sf, sfl, dc, df, ef, ev, bc, bl, r;

        #2 rst_n = 1'b0;
        #13;
        chk("reset_S", int'(S), 0);
        chk("reset_R", int'(R), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_rdy", int'(req_ready), 1);
        #17 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // 1: set from cleared latch
        run_op(1, 0, 24, sc, rc, sf, sfl, dc, df, ef, ev, bc, bl);
        chk("s1_s_cycles", sc, P);
        chk("s1_s_first", sf, 1);
        chk("s1_r_cycles", rc, 0);
        chk("s1_done_count", dc, 1);
        chk("s1_done_window", int'(df > sfl && df <= sfl + TO), 1);
        chk("s1_gap_len", bl - df + 1, G);
        chk("s1_Q", int'(Q_fb), 1);
        chk("s1_Qbar", int'(Qbar_fb), 0);

        // 2: clear from set latch
        run_op(0, 1, 24, sc, rc, sf, sfl, dc, df, ef, ev, bc, bl);
        chk("s2_r_cycles", rc, P);
        chk("s2_s_cycles", sc, 0);
        chk("s2_done_count", dc, 1);
        chk("s2_err_change", ef, 0);
        chk("s2_Q", int'(Q_fb), 0);
        chk("s2_Qbar", int'(Qbar_fb), 1);

        // 3: conflicting request, then err_clr
        run_op(1, 1, 8, sc, rc, sf, sfl, dc, df, ef, ev, bc, bl);
        chk("s3_s_cycles", sc, 0);
        chk("s3_r_cycles", rc, 0);
        chk("s3_busy", bc, 0);
        chk("s3_err_val", ev, 1);
        chk("s3_err_when", ef, 1);
        @(posedge clk); #1;
        err_clr = 1'b1;
        chk("s3_err_before_clr", int'(err), 1);
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("s3_err_after_clr", int'(err), 0);

        // 4: feedback stuck cleared -> timeout
        ovr = 1;
        repeat (4) @(posedge clk);
        run_op(1, 0, 24, sc, rc, sf, sfl, dc, df, ef, ev, bc, bl);
        chk("s4_s_cycles", sc, P);
        chk("s4_done_count", dc, 0);
        chk("s4_err_val", ev, 2);
        chk("s4_err_delay", ef - sfl, TO);
        chk("s4_gap_len", bl - ef + 1, G);
        chk("s4_model_err", int'(exp_err), 2);
        ovr = 0;
        repeat (4) @(posedge clk);

        // 5: latch already set
        run_op(1, 0, 12, sc, rc, sf, sfl, dc, df, ef, ev, bc, bl);
        chk("s5_s_cycles", sc, 0);
        chk("s5_r_cycles", rc, 0);
        chk("s5_done_count", dc, 1);
        chk("s5_done_first", df, 1);
        chk("s5_busy_cycles", bc, G);

        // 6: reset during the 2nd pulse cycle
        run_op(0, 1, 24, sc, rc, sf, sfl, dc, df, ef, ev, bc, bl);
        chk("s6_pre_clear_done", dc, 1);
        @(posedge clk); #1;
        set_req = 1'b1;
        @(posedge clk); #1;
        set_req = 1'b0;
        @(posedge clk); #3;
        chk("s6_S_2nd_pulse", int'(S), 1);
        rst_n = 1'b0;
        #1;
        chk("s6_S_async", int'(S), 0);
        chk("s6_R_async", int'(R), 0);
        chk("s6_rdy_async", int'(req_ready), 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("s6_rdy_release", int'(req_ready), 1);
        chk("s6_err_release", int'(err), 0);
        dc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) dc++;
        end
        chk("s6_no_done", dc, 0);

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            r = $urandom_range(0, 99);
            set_req = (r < 20) || (r >= 95);
            clr_req = (r >= 20 && r < 40) || (r >= 95);
            err_clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) ovr = $urandom_range(0, 2);
        end
        @(posedge clk); #1;
        set_req = 1'b0; clr_req = 1'b0; err_clr = 1'b0; ovr = 0;
        repeat (20) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
